// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_e;

  localparam int unsigned RETRY_W = 32'd4;

  // Width needed to count up to the longest of the three phase lengths.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 32'd2) return 32'd1;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser with synchronous active-low reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL reset, retries on lock timeout, and releases the core reset
// only after lock has been continuously stable.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_PULSE_CYC    = 32'd8,
  parameter int unsigned LOCK_TIMEOUT_CYC = 32'd50000,
  parameter int unsigned STABLE_CYC       = 32'd1024,
  parameter int unsigned MAX_RETRIES      = 32'd4
) (
  input  logic               refclk_i,
  input  logic               rst_n_i,
  input  logic               pll_locked_i,
  input  logic               relock_req_i,
  output logic               pll_rst_o,
  output logic               sys_rst_n_o,
  output logic               ready_o,
  output logic               fail_o,
  output logic [RETRY_W-1:0] retry_cnt_o
);

  localparam int unsigned CNT_W = cnt_width(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC);
  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYC - 32'd1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT_CYC - 32'd1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYC - 32'd1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  pll_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               pll_rst_q, sys_rst_n_q, ready_q, fail_q;
  logic               lock_s;

  sync_2ff u_lock_sync (
    .clk_i   (refclk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pll_locked_i),
    .q_o     (lock_s)
  );

  // Lock wins over a same-cycle timeout; relock_req only matters in RUN and FAIL.
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = cnt_q;
    case (state_q)
      RESET_PLL: begin
        if (cnt_q == RST_LAST) state_d = WAIT_LOCK;
        else                   state_d = RESET_PLL;
      end
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = STABLE;
        end else if (cnt_q == TO_LAST) begin
          if (retry_q == RETRY_MAX) begin
            state_d = FAIL;
          end else begin
            state_d = RESET_PLL;
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          state_d = WAIT_LOCK;
        end
      end
      STABLE: begin
        if (!lock_s)                    state_d = WAIT_LOCK;
        else if (cnt_q == STABLE_LAST)  state_d = RUN;
        else                            state_d = STABLE;
      end
      RUN: begin
        if (!lock_s || relock_req_i) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end else begin
          state_d = RUN;
        end
      end
      FAIL: begin
        if (relock_req_i) begin
          state_d = RESET_PLL;
          retry_d = '0;
        end else begin
          state_d = FAIL;
        end
      end
      default: begin
        state_d = RESET_PLL;
        retry_d = '0;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
    else                    cnt_d = cnt_q + CNT_W'(1);
  end

  // Outputs are decoded from the next state so they change with the state register.
  always_ff @(posedge refclk_i) begin
    if (!rst_n_i) begin
      state_q     <= RESET_PLL;
      cnt_q       <= '0;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= (state_d == RESET_PLL);
      sys_rst_n_q <= (state_d == RUN);
      ready_q     <= (state_d == RUN);
      fail_q      <= (state_d == FAIL);
    end
  end

  assign pll_rst_o   = pll_rst_q;
  assign sys_rst_n_o = sys_rst_n_q;
  assign ready_o     = ready_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: a timestamp-based phase model checked
// every cycle, plus hand-computed latency/pulse expectations.
module tb_pll_reset_sequencer;

  localparam int RST = 4;
  localparam int TO  = 20;
  localparam int ST  = 8;
  localparam int MR  = 2;

  localparam logic [2:0] PH_PULSE  = 3'd0;
  localparam logic [2:0] PH_WAIT   = 3'd1;
  localparam logic [2:0] PH_STABLE = 3'd2;
  localparam logic [2:0] PH_RUN    = 3'd3;
  localparam logic [2:0] PH_FAIL   = 3'd4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fail;
  logic [3:0] retry_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 clk = ~clk;

  pll_reset_sequencer #(
    .RST_PULSE_CYC    (RST),
    .LOCK_TIMEOUT_CYC (TO),
    .STABLE_CYC       (ST),
    .MAX_RETRIES      (MR)
  ) dut (
    .refclk_i     (clk),
    .rst_n_i      (rst_n),
    .pll_locked_i (pll_locked),
    .relock_req_i (relock_req),
    .pll_rst_o    (pll_rst),
    .sys_rst_n_o  (sys_rst_n),
    .ready_o      (ready),
    .fail_o       (fail),
    .retry_cnt_o  (retry_cnt)
  );

  // Model: phase plus the edge index at which it was entered; lock seen by the
  // sequencer at edge k is the raw input from edge k-2, cleared by reset.
  typedef struct packed {
    logic [2:0]  phase;
    logic [31:0] since;
    logic [3:0]  retries;
  } mstate_t;

  mstate_t m;
  bit      m_valid = 1'b0;
  bit      eff_hist  [0:4095];
  bit      rstn_hist [0:4095];
  int      cyc = 2;

  function automatic bit lock_seen(input int k);
    return rstn_hist[k-1] & eff_hist[k-2];
  endfunction

  function automatic mstate_t step(input mstate_t m0, input int k, input bit rstn,
                                   input bit lk, input bit relock);
    mstate_t n;
    int age;
    n = m0;
    age = k - int'(m0.since);
    if (!rstn) begin
      n.phase = PH_PULSE; n.since = 32'(k); n.retries = 4'd0;
      return n;
    end
    case (m0.phase)
      PH_PULSE:  if (age == RST) begin n.phase = PH_WAIT; n.since = 32'(k); end
      PH_WAIT: begin
        if (lk) begin
          n.phase = PH_STABLE; n.since = 32'(k);
        end else if (age == TO) begin
          n.since = 32'(k);
          if (int'(m0.retries) == MR) n.phase = PH_FAIL;
          else begin n.phase = PH_PULSE; n.retries = m0.retries + 4'd1; end
        end
      end
      PH_STABLE: begin
        if (!lk) begin n.phase = PH_WAIT; n.since = 32'(k); end
        else if (age == ST) begin n.phase = PH_RUN; n.since = 32'(k); end
      end
      PH_RUN:  if (!lk || relock) begin n.phase = PH_PULSE; n.since = 32'(k); n.retries = 4'd0; end
      PH_FAIL: if (relock) begin n.phase = PH_PULSE; n.since = 32'(k); n.retries = 4'd0; end
      default: begin n.phase = PH_PULSE; n.since = 32'(k); n.retries = 4'd0; end
    endcase
    return n;
  endfunction

  always @(posedge clk) begin
    eff_hist[cyc]  <= rst_n & pll_locked;
    rstn_hist[cyc] <= rst_n;
    m              <= step(m, cyc, rst_n, lock_seen(cyc), relock_req);
    if (!rst_n) m_valid <= 1'b1;
    cyc <= cyc + 1;
    if (cyc > 4000) begin
      $display("FAIL watchdog: cycle %0d exceeds budget 4000", cyc);
      $fatal(1);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one cycle and compare every output against the model.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    if (m_valid) begin
      check("model_pll_rst",   32'(pll_rst),   32'(m.phase == PH_PULSE));
      check("model_sys_rst_n", 32'(sys_rst_n), 32'(m.phase == PH_RUN));
      check("model_ready",     32'(ready),     32'(m.phase == PH_RUN));
      check("model_fail",      32'(fail),      32'(m.phase == PH_FAIL));
      check("model_retry_cnt", 32'(retry_cnt), 32'(m.retries));
    end
  endtask

  task automatic pulse_len(output int len);
    int guard;
    len = 0;
    guard = 0;
    while (pll_rst !== 1'b1 && guard < 200) begin tick(); guard++; end
    while (pll_rst === 1'b1 && len < 200) begin len++; tick(); end
  endtask

  task automatic cycles_until_ready(output int n);
    n = 0;
    while (ready !== 1'b1 && n < 300) begin tick(); n++; end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"},   32'(pll_rst),   32'd1);
    check({tag, "_sys_rst_n"}, 32'(sys_rst_n), 32'd0);
    check({tag, "_ready"},     32'(ready),     32'd0);
    check({tag, "_fail"},      32'(fail),      32'd0);
    check({tag, "_retry"},     32'(retry_cnt), 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    logic prev;

    rst_n = 1'b0;
    repeat (3) tick();
    check_reset_values("reset");

    // Clean lock
    rst_n = 1'b1;
    pulse_len(n);
    check("clean_pulse_len", 32'(n), 32'd4);
    repeat (5) tick();
    pll_locked = 1'b1;
    cycles_until_ready(n);
    check("clean_lock_to_ready", 32'(n), 32'd11);
    check("clean_sys_rst_n", 32'(sys_rst_n), 32'd1);
    check("clean_retry", 32'(retry_cnt), 32'd0);

    // Lock loss in RUN
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst_n === 1'b1 && n < 50) begin tick(); n++; end
    check("loss_latency", 32'(n), 32'd3);
    check("loss_ready", 32'(ready), 32'd0);
    check("loss_pll_rst", 32'(pll_rst), 32'd1);
    check("loss_retry", 32'(retry_cnt), 32'd0);

    // Timeout then lock
    pulse_len(n);
    check("loss_pulse_len", 32'(n), 32'd4);
    n = 0;
    while (pll_rst !== 1'b1 && n < 100) begin tick(); n++; end
    check("timeout_wait_len", 32'(n), 32'd20);
    check("timeout_retry", 32'(retry_cnt), 32'd1);
    pulse_len(n);
    check("retry_pulse_len", 32'(n), 32'd4);
    pll_locked = 1'b1;
    cycles_until_ready(n);
    check("retry_lock_to_ready", 32'(n), 32'd11);
    check("retry_run_retry", 32'(retry_cnt), 32'd1);

    // Relock request from RUN, then a one-cycle glitch during STABLE
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("relock_ready", 32'(ready), 32'd0);
    check("relock_retry", 32'(retry_cnt), 32'd0);
    pulse_len(n);
    check("relock_pulse_len", 32'(n), 32'd4);
    repeat (4) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    cycles_until_ready(n);
    check("glitch_restore_to_ready", 32'(n), 32'd11);
    check("glitch_retry", 32'(retry_cnt), 32'd0);

    // Failure: lock never returns
    pll_locked = 1'b0;
    pulses = 0;
    prev = 1'b0;
    n = 0;
    while (fail !== 1'b1 && n < 400) begin
      if (pll_rst === 1'b1 && !prev) pulses++;
      prev = pll_rst;
      tick();
      n++;
    end
    check("fail_pulses", 32'(pulses), 32'd3);
    check("fail_flag", 32'(fail), 32'd1);
    check("fail_retry", 32'(retry_cnt), 32'd2);
    check("fail_sys_rst_n", 32'(sys_rst_n), 32'd0);
    check("fail_pll_rst", 32'(pll_rst), 32'd0);
    repeat (5) tick();
    check("fail_hold", 32'(fail), 32'd1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("fail_relock_fail", 32'(fail), 32'd0);
    check("fail_relock_pll_rst", 32'(pll_rst), 32'd1);
    check("fail_relock_retry", 32'(retry_cnt), 32'd0);

    // Reset mid-sequence during WAIT_LOCK with one retry used
    n = 0;
    while (retry_cnt !== 4'd1 && n < 100) begin tick(); n++; end
    pulse_len(n);
    repeat (3) tick();
    check("mid_wait_retry", 32'(retry_cnt), 32'd1);
    relock_req = 1'b1;
    tick();
    relock_req = 1'b0;
    check("mid_wait_relock_ignored", 32'(pll_rst), 32'd0);
    rst_n = 1'b0;
    tick();
    check_reset_values("midrst");
    rst_n = 1'b1;
    pulse_len(n);
    check("midrst_pulse_len", 32'(n), 32'd4);
    check("midrst_retry", 32'(retry_cnt), 32'd0);

    repeat (3) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Controller for the other end of the clock generator's rst/locked handshake. It drives the PLL/DCM reset and watches the asynchronous lock indication. It retries on lock timeout and releases the system reset only after lock has been continuously stable. It runs in the free-running 50 MHz reference domain and feeds the reset tree of the 52 MHz core domain.

Parameters:
RST_PULSE_CYC, 8, cycles pll_rst is held high per attempt (DCM needs at least 3 CLKIN cycles)
LOCK_TIMEOUT_CYC, 50000, cycles to wait for lock before a retry (1 ms at 50 MHz)
STABLE_CYC, 1024, consecutive locked cycles required before system reset release
MAX_RETRIES, 4, retries after the first attempt before declaring failure (at most 15)

Ports:
refclk  in  1  50 MHz reference clock, free-running
rst_n  in  1  synchronous active-low reset
pll_locked  in  1  PLL/DCM locked, asynchronous to refclk
relock_req  in  1  one-cycle request to re-run the sequence (RUN and FAIL only)
pll_rst  out  1  active-high PLL/DCM reset
sys_rst_n  out  1  active-low system reset, registered
ready  out  1  high in RUN
fail  out  1  high in FAIL
retry_cnt  out  4  retries used in the current sequence

Behaviour:
- One clock, refclk. rst_n is synchronous and active-low. All outputs are registered.
- Reset values: state=RESET_PLL, cnt=0, pll_rst=1, sys_rst_n=0, ready=0, fail=0, retry_cnt=0, sync flops=0.
- Synchroniser: pll_locked passes through 2 flops to give lock_s. Latency is 2 cycles.
- cnt width: clog2 of max(RST_PULSE_CYC, LOCK_TIMEOUT_CYC, STABLE_CYC). cnt clears on every state change.
- RESET_PLL:
  - pll_rst=1.
  - When cnt==RST_PULSE_CYC-1, go to WAIT_LOCK.
  - pll_rst is therefore high for exactly RST_PULSE_CYC cycles.
- WAIT_LOCK:
  - pll_rst=0.
  - If lock_s=1, go to STABLE. Lock takes priority over a timeout in the same cycle.
  - Otherwise, on cnt==LOCK_TIMEOUT_CYC-1:
    - if retry_cnt==MAX_RETRIES, go to FAIL;
    - else increment retry_cnt and go to RESET_PLL.
- STABLE:
  - If lock_s=0, go to WAIT_LOCK with cnt cleared. retry_cnt is unchanged; the timeout restarts.
  - On cnt==STABLE_CYC-1 with lock_s=1, go to RUN.
- RUN:
  - sys_rst_n=1 and ready=1, both from the first RUN cycle.
  - retry_cnt is frozen.
  - lock_s=0 for even one cycle, or relock_req=1: go to RESET_PLL, retry_cnt=0. sys_rst_n and ready drop in the same registered update.
  - Both events in the same cycle are treated identically.
- FAIL:
  - fail=1, pll_rst=0, sys_rst_n=0.
  - Holds until relock_req, which clears fail, sets retry_cnt=0 and goes to RESET_PLL.
- relock_req is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- sys_rst_n=0 in every state except RUN.
- rst_n low mid-sequence: next cycle returns to reset values, restarting pll_rst high. No partial state survives.
- Total attempts = MAX_RETRIES+1.

Decomposition:
- Package pll_seq_pkg:
  - state enum {RESET_PLL, WAIT_LOCK, STABLE, RUN, FAIL}, 3-bit encoding;
  - cnt width function;
  - retry_cnt width constant (4).
- Sub-module sync_2ff: 2-flop level synchroniser with synchronous active-low reset. It is reused later for other cross-domain status bits.

Test Plan:
All scenarios use RST_PULSE_CYC=4, LOCK_TIMEOUT_CYC=20, STABLE_CYC=8, MAX_RETRIES=2.
- Clean lock: release rst_n; raise pll_locked 5 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst_n and ready rise 2+1+8 cycles after pll_locked rises; retry_cnt=0.
- Timeout then lock: keep locked low through one full 20-cycle wait, raise it in the second attempt -> second pll_rst pulse of 4 cycles; retry_cnt=1 in RUN.
- Failure: locked never rises -> 3 pll_rst pulses, then fail=1 with retry_cnt=2 and sys_rst_n=0. A subsequent relock_req gives fail=0, a new pll_rst pulse, and retry_cnt=0.
- Glitch during STABLE: drop locked for 1 cycle after 5 stable cycles -> returns to WAIT_LOCK; ready rises a full 8 stable cycles after relock; retry_cnt unchanged.
- Lock loss in RUN: drop pll_locked -> sys_rst_n=0 and ready=0 exactly 3 cycles after the drop (2 synchroniser cycles + 1 registered update); pll_rst high the same cycle; retry_cnt=0.
- Reset mid-sequence: assert rst_n low during WAIT_LOCK with retry_cnt=1 -> all outputs at reset values next cycle; sequence restarts from RESET_PLL.
